// File: rtl/dbus_router_pkg.sv
// Shared types and helpers for the data-bus router and its address decoder.
package dbus_router_pkg;

    typedef enum logic [1:0] {
        DBUS_IDLE = 2'd0,
        DBUS_WAIT = 2'd1,
        DBUS_ERR  = 2'd2
    } dbus_state_e;

    localparam int DBUS_CNT_W = 16;

    // Index width that stays legal for a single-slot router.
    function automatic int dbus_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dbus_addr_match.sv
// Combinational priority address decoder: lowest-index matching slot wins.
module dbus_addr_match
    import dbus_router_pkg::*;
#(
    parameter int                            WORD_LEN   = 32,
    parameter int                            NUM_DEV    = 4,
    parameter int                            IDX_W      = dbus_idx_w(NUM_DEV),
    parameter logic [NUM_DEV*WORD_LEN-1:0]   BASE_ADDRS = '0,
    parameter logic [NUM_DEV*WORD_LEN-1:0]   ADDR_MASKS = '0
) (
    input  logic [WORD_LEN-1:0] addr_i,
    output logic [NUM_DEV-1:0]  hit_o,
    output logic [IDX_W-1:0]    idx_o,
    output logic                miss_o
);

    logic [NUM_DEV-1:0] raw_hit_s;

    for (genvar k = 0; k < NUM_DEV; k++) begin : g_slot
        assign raw_hit_s[k] = ((addr_i & ADDR_MASKS[k*WORD_LEN +: WORD_LEN])
                               == BASE_ADDRS[k*WORD_LEN +: WORD_LEN]);
    end

    // Descending scan so the lowest hitting index is the last one written.
    always_comb begin
        idx_o = '0;
        for (int k = NUM_DEV - 1; k >= 0; k--) begin
            idx_o = raw_hit_s[k] ? IDX_W'(k) : idx_o;
        end
        miss_o = ~|raw_hit_s;
        hit_o  = miss_o ? '0 : (NUM_DEV'(1) << idx_o);
    end

endmodule

// File: rtl/dbus_router.sv
// Data-bus router: decodes the core request to one device, waits for its
// ready with a timeout, and reports unmapped/timeout errors with sticky capture.
module dbus_router
    import dbus_router_pkg::*;
#(
    parameter int                            WORD_LEN   = 32,
    parameter int                            NUM_DEV    = 4,
    parameter logic [NUM_DEV*WORD_LEN-1:0]   BASE_ADDRS = '0,
    parameter logic [NUM_DEV*WORD_LEN-1:0]   ADDR_MASKS = '0,
    parameter int                            TIMEOUT    = 255
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         c_req,
    input  logic                         c_wen,
    input  logic [WORD_LEN-1:0]          c_addr,
    input  logic [WORD_LEN-1:0]          c_wdata,
    output logic [WORD_LEN-1:0]          c_rdata,
    output logic                         c_ack,
    output logic                         c_err,
    output logic [NUM_DEV-1:0]           d_sel,
    output logic                         d_wen,
    output logic [WORD_LEN-1:0]          d_addr,
    output logic [WORD_LEN-1:0]          d_wdata,
    input  logic [NUM_DEV*WORD_LEN-1:0]  d_rdata,
    input  logic [NUM_DEV-1:0]           d_ready,
    output logic                         err_valid,
    output logic [WORD_LEN-1:0]          err_addr,
    input  logic                         err_clr
);

    localparam int                    IDX_W    = dbus_idx_w(NUM_DEV);
    localparam logic [DBUS_CNT_W-1:0] CNT_LAST = DBUS_CNT_W'(TIMEOUT - 1);

    dbus_state_e           state_q, state_d;
    logic [IDX_W-1:0]      sel_q, sel_d;
    logic [DBUS_CNT_W-1:0] cnt_q, cnt_d;
    logic                  err_valid_q, err_valid_d;
    logic [WORD_LEN-1:0]   err_addr_q, err_addr_d;

    logic [NUM_DEV-1:0]    hit_s;
    logic [IDX_W-1:0]      idx_s;
    logic                  miss_s;
    logic [WORD_LEN-1:0]   rdata_sel_s, rdata_s;
    logic                  ready_sel_s, timeout_s, ack_s, err_s, dwen_s;
    logic [NUM_DEV-1:0]    dsel_s;

    dbus_addr_match #(
        .WORD_LEN   (WORD_LEN),
        .NUM_DEV    (NUM_DEV),
        .IDX_W      (IDX_W),
        .BASE_ADDRS (BASE_ADDRS),
        .ADDR_MASKS (ADDR_MASKS)
    ) u_match (
        .addr_i (c_addr),
        .hit_o  (hit_s),
        .idx_o  (idx_s),
        .miss_o (miss_s)
    );

    // Route the latched slot's read data and ready back to the core side.
    always_comb begin
        rdata_sel_s = '0;
        ready_sel_s = 1'b0;
        for (int k = 0; k < NUM_DEV; k++) begin
            rdata_sel_s = (sel_q == IDX_W'(k)) ? d_rdata[k*WORD_LEN +: WORD_LEN] : rdata_sel_s;
            ready_sel_s = (sel_q == IDX_W'(k)) ? d_ready[k] : ready_sel_s;
        end
        timeout_s = (cnt_q == CNT_LAST);
    end

    // FSM, slot and wait-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DBUS_IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; ready takes precedence over timeout.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        case (state_q)
            DBUS_IDLE: begin
                if (c_req && miss_s) begin
                    state_d = DBUS_ERR;
                end else if (c_req) begin
                    state_d = DBUS_WAIT;
                    sel_d   = idx_s;
                    cnt_d   = '0;
                end else begin
                    state_d = DBUS_IDLE;
                end
            end
            DBUS_WAIT: begin
                if (ready_sel_s || timeout_s) begin
                    state_d = DBUS_IDLE;
                end else begin
                    cnt_d = cnt_q + DBUS_CNT_W'(1);
                end
            end
            DBUS_ERR: state_d = DBUS_IDLE;
            default:  state_d = DBUS_IDLE;
        endcase
    end

    // Core/device outputs; read data is forced to zero except on a good ack.
    always_comb begin
        ack_s   = 1'b0;
        err_s   = 1'b0;
        rdata_s = '0;
        dsel_s  = '0;
        dwen_s  = 1'b0;
        case (state_q)
            DBUS_IDLE: begin
                if (c_req && !miss_s) begin
                    dsel_s = hit_s;
                    dwen_s = c_wen;
                end else begin
                    dsel_s = '0;
                end
            end
            DBUS_WAIT: begin
                if (ready_sel_s) begin
                    ack_s   = 1'b1;
                    rdata_s = rdata_sel_s;
                end else if (timeout_s) begin
                    ack_s = 1'b1;
                    err_s = 1'b1;
                end else begin
                    ack_s = 1'b0;
                end
            end
            DBUS_ERR: begin
                ack_s = 1'b1;
                err_s = 1'b1;
            end
            default: ack_s = 1'b0;
        endcase
    end

    // Sticky error capture; a new error beats a concurrent clear.
    always_comb begin
        err_valid_d = err_valid_q;
        err_addr_d  = err_addr_q;
        if (ack_s && err_s) begin
            err_valid_d = 1'b1;
            err_addr_d  = (!err_valid_q || err_clr) ? c_addr : err_addr_q;
        end else if (err_clr) begin
            err_valid_d = 1'b0;
        end else begin
            err_valid_d = err_valid_q;
        end
    end

    // Error capture registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            err_valid_q <= err_valid_d;
            err_addr_q  <= err_addr_d;
        end
    end

    assign c_ack     = ack_s;
    assign c_err     = err_s;
    assign c_rdata   = rdata_s;
    assign d_sel     = dsel_s;
    assign d_wen     = dwen_s;
    assign d_addr    = c_addr;
    assign d_wdata   = c_wdata;
    assign err_valid = err_valid_q;
    assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_dbus_router.sv
// Self-checking bench for dbus_router: directed cases then randomized traffic
// against an address-range/latency reference model.
module tb_dbus_router;

    localparam int WL = 32;
    localparam int ND = 3;
    localparam int TO = 8;
    localparam logic [ND*WL-1:0] BASES = {32'h1000_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [ND*WL-1:0] MASKS = {32'hFFFF_0000, 32'hFFFF_FFF8, 32'hFFFF_0000};

    logic          clk;
    logic          rst_n;
    logic          c_req, c_wen, err_clr;
    logic [WL-1:0] c_addr, c_wdata;
    logic [WL-1:0] c_rdata, d_addr, d_wdata, err_addr;
    logic          c_ack, c_err, d_wen, err_valid;
    logic [ND-1:0] d_sel, d_ready;
    logic [WL-1:0] dev_data [ND];
    logic [ND*WL-1:0] d_rdata;

    int checks = 0;
    int errors = 0;
    bit            mdl_ev;
    logic [WL-1:0] mdl_ea;

    assign d_rdata = {dev_data[2], dev_data[1], dev_data[0]};

    dbus_router #(
        .WORD_LEN   (WL),
        .NUM_DEV    (ND),
        .BASE_ADDRS (BASES),
        .ADDR_MASKS (MASKS),
        .TIMEOUT    (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .c_req     (c_req),
        .c_wen     (c_wen),
        .c_addr    (c_addr),
        .c_wdata   (c_wdata),
        .c_rdata   (c_rdata),
        .c_ack     (c_ack),
        .c_err     (c_err),
        .d_sel     (d_sel),
        .d_wen     (d_wen),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .err_valid (err_valid),
        .err_addr  (err_addr),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    // Memory map expressed as address ranges: mem, uart, then a wider IO window.
    function automatic int ref_slot(input logic [WL-1:0] a);
        if (a < 32'h0001_0000) return 0;
        if (a >= 32'h1000_0000 && a <= 32'h1000_0007) return 1;
        if (a >= 32'h1000_0000 && a <= 32'h1000_FFFF) return 2;
        return -1;
    endfunction

    task automatic check(input string tag, input logic [WL-1:0] obs, input logic [WL-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One transaction; w = device wait cycles (ready arrives in cycle w+1).
    task automatic run_txn(input logic [WL-1:0] addr, input logic wen,
                           input logic [WL-1:0] wdata, input int w, input bit clr_at_ack);
        int slot, exp_cyc;
        bit exp_err, done;
        logic [WL-1:0] exp_rd;
        logic [ND-1:0] r;
        slot = ref_slot(addr);
        for (int k = 0; k < ND; k++) dev_data[k] = $urandom;
        if (slot < 0) begin
            exp_cyc = 1; exp_err = 1'b1;
        end else if (w + 1 <= TO) begin
            exp_cyc = w + 1; exp_err = 1'b0;
        end else begin
            exp_cyc = TO; exp_err = 1'b1;
        end
        exp_rd = 32'h0;
        if (!exp_err) exp_rd = dev_data[slot];
        c_req = 1'b1; c_wen = wen; c_addr = addr; c_wdata = wdata;
        d_ready = 3'($urandom);
        #1;
        check("d_sel_c0", 32'(d_sel), (slot < 0) ? 32'h0 : (32'h1 << slot));
        check("d_wen_c0", 32'(d_wen), (slot < 0) ? 32'h0 : 32'(wen));
        check("c_ack_c0", 32'(c_ack), 32'h0);
        check("d_addr", d_addr, addr);
        check("d_wdata", d_wdata, wdata);
        done = 1'b0;
        for (int c = 1; c <= 20 && !done; c++) begin
            @(negedge clk);
            r = 3'($urandom);
            if (slot >= 0) r[slot] = (c == w + 1);
            d_ready = r;
            if (clr_at_ack && c == exp_cyc) err_clr = 1'b1;
            #1;
            check("c_ack", 32'(c_ack), 32'(c == exp_cyc));
            check("d_sel_wait", 32'(d_sel), 32'h0);
            if (c == exp_cyc) begin
                check("c_err", 32'(c_err), 32'(exp_err));
                check("c_rdata_ack", c_rdata, exp_rd);
                if (exp_err && (!mdl_ev || clr_at_ack)) begin
                    mdl_ev = 1'b1; mdl_ea = addr;
                end else if (clr_at_ack && !exp_err) begin
                    mdl_ev = 1'b0;
                end
                done = 1'b1;
                c_req = 1'b0;
            end else begin
                check("c_rdata_idle", c_rdata, 32'h0);
            end
        end
        @(negedge clk);
        err_clr = 1'b0; d_ready = '0;
        #1;
        check("err_valid", 32'(err_valid), 32'(mdl_ev));
        check("err_addr", err_addr, mdl_ea);
        check("c_ack_after", 32'(c_ack), 32'h0);
    endtask

    task automatic clear_err();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        mdl_ev = 1'b0;
        #1;
        check("err_clr_valid", 32'(err_valid), 32'h0);
        check("err_clr_addr", err_addr, mdl_ea);
    endtask

    initial begin
        logic [WL-1:0] addr;
        clk = 1'b0; rst_n = 1'b0; c_req = 1'b0; c_wen = 1'b0; err_clr = 1'b0;
        c_addr = '0; c_wdata = '0; d_ready = '0;
        for (int k = 0; k < ND; k++) dev_data[k] = '0;
        mdl_ev = 1'b0; mdl_ea = '0;
        #1;
        check("rst_ack", 32'(c_ack), 32'h0);
        check("rst_err", 32'(c_err), 32'h0);
        check("rst_rdata", c_rdata, 32'h0);
        check("rst_dsel", 32'(d_sel), 32'h0);
        check("rst_errv", 32'(err_valid), 32'h0);
        check("rst_erra", err_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        run_txn(32'h0000_0010, 1'b0, 32'h0, 0, 1'b0);          // zero-wait memory read
        run_txn(32'h1000_0004, 1'b1, 32'h41, 3, 1'b0);         // uart write, 3 waits
        run_txn(32'h2000_0000, 1'b0, 32'h0, 0, 1'b0);          // unmapped
        clear_err();
        run_txn(32'h1000_0000, 1'b0, 32'h0, 100, 1'b0);        // uart timeout
        run_txn(32'h2000_0004, 1'b0, 32'h0, 0, 1'b0);          // second error keeps first addr
        clear_err();
        run_txn(32'h1000_0010, 1'b0, 32'h0, 1, 1'b0);          // only the wide IO slot hits
        run_txn(32'h1000_0006, 1'b0, 32'h0, 7, 1'b0);          // ready on timeout cycle
        run_txn(32'h3000_0000, 1'b0, 32'h0, 0, 1'b0);
        run_txn(32'h4000_0008, 1'b1, 32'h5, 0, 1'b1);          // error beats clear
        run_txn(32'h0000_FFFC, 1'b1, 32'h7, 2, 1'b1);          // clear on good ack

        // Reset during WAIT cycle 2
        c_req = 1'b1; c_wen = 1'b0; c_addr = 32'h1000_0000; d_ready = '0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0; c_req = 1'b0;
        #1;
        mdl_ev = 1'b0; mdl_ea = '0;
        check("mrst_ack", 32'(c_ack), 32'h0);
        check("mrst_err", 32'(c_err), 32'h0);
        check("mrst_rdata", c_rdata, 32'h0);
        check("mrst_dsel", 32'(d_sel), 32'h0);
        check("mrst_dwen", 32'(d_wen), 32'h0);
        check("mrst_errv", 32'(err_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mrst_stale_ack", 32'(c_ack), 32'h0);
        run_txn(32'h0000_0100, 1'b0, 32'h0, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0: addr = {16'h0000, 16'($urandom)};
                1: addr = 32'h1000_0000 + 32'($urandom_range(0, 7));
                2: addr = 32'h1000_0008 + 32'($urandom_range(0, 32'h0000_FFF7));
                3: addr = 32'h2000_0000 | 32'($urandom_range(0, 255));
                default: addr = $urandom;
            endcase
            run_txn(addr, 1'($urandom_range(0, 1)), $urandom,
                    $urandom_range(0, 9), ($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dbus_router.md
Name: dbus_router

Overview:
- Parametrised data-bus router between the core data port and NUM_DEV memory-mapped devices (memory, uart, timer, gpio ...).
- Replaces the fixed two-way memory/uart select and its one-cycle-delayed read mux.
- Adds per-device ready handshake (wait states), priority address decode, unmapped-address and timeout bus errors, and a sticky error capture register.

Parameters:
- WORD_LEN, 32 (`WORD_LEN from consts.vh): data/address width.
- NUM_DEV, 4: number of device slots, 1..8.
- BASE_ADDRS, {NUM_DEV{WORD_LEN'h0}}: flat vector; slot k base at bits [k*WORD_LEN +: WORD_LEN].
- ADDR_MASKS, {NUM_DEV{WORD_LEN'h0}}: flat vector; slot k hits when (addr & mask_k) == base_k.
- TIMEOUT, 255: maximum WAIT cycles before a timeout error, 1..65535.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- c_req  in  1  core request; addr/wen/wdata held stable until c_ack.
- c_wen  in  1  1 = write, 0 = read.
- c_addr  in  WORD_LEN  core address.
- c_wdata  in  WORD_LEN  write data.
- c_rdata  out  WORD_LEN  read data, valid only with c_ack.
- c_ack  out  1  one-cycle completion pulse.
- c_err  out  1  bus error, qualifies c_ack.
- d_sel  out  NUM_DEV  one-hot device request pulse.
- d_wen  out  1  write strobe, qualified by d_sel.
- d_addr  out  WORD_LEN  device address (= c_addr).
- d_wdata  out  WORD_LEN  device write data (= c_wdata).
- d_rdata  in  NUM_DEV*WORD_LEN  flat per-device read data.
- d_ready  in  NUM_DEV  per-device completion.
- err_valid  out  1  sticky error flag.
- err_addr  out  WORD_LEN  address of the first captured error.
- err_clr  in  1  clears err_valid.

Behaviour:
- Reset values: state IDLE, c_ack 0, c_err 0, c_rdata 0, d_sel 0, d_wen 0, err_valid 0, err_addr 0, timeout counter 0, sel_q 0. Reset asserted mid-transaction aborts to IDLE immediately; no ack is issued.
- Decode is combinational on c_addr. The lowest-index hitting slot wins. No hit = unmapped.
- States: IDLE, WAIT, ERR.
- IDLE, c_req=1 and hit slot k:
  - d_sel[k]=1 and d_wen=c_wen in this cycle (cycle 0).
  - Register sel_q=k and cnt=0; go to WAIT.
- IDLE, c_req=1 and unmapped:
  - d_sel stays 0; go to ERR.
- WAIT:
  - d_sel=0. c_rdata is driven from d_rdata[sel_q].
  - If d_ready[sel_q]: c_ack=1, c_err=0, go to IDLE.
  - Else if cnt==TIMEOUT-1: c_ack=1, c_err=1, c_rdata=0, go to IDLE.
  - Else cnt++.
  - Ready and timeout in the same cycle: ready wins.
  - d_ready on other slots is ignored.
- ERR: c_ack=1, c_err=1, c_rdata=0 for one cycle, then IDLE. Writes are dropped.
- Latency:
  - Zero-wait device (ready in cycle 1, the same as sync memory): ack in cycle 1.
  - Each device wait cycle adds 1.
  - Timeout ack arrives TIMEOUT cycles after cycle 0.
- Throughput: a new request is accepted only in IDLE, i.e. the cycle after c_ack. Peak rate is 1 per 2 cycles.
- c_rdata outside c_ack is 0.
- Error capture:
  - On any c_err ack: if err_valid=0, set err_valid=1 and err_addr=c_addr.
  - If err_valid=1, err_addr holds the first error address.
  - err_clr clears err_valid and leaves err_addr unchanged.
  - err_clr in the same cycle as a new error: the error wins (set, and addr captured).
- c_req deasserting while in WAIT is a protocol violation; the router still completes the transaction.

Decomposition:
- consts.vh holds:
  - DBUS_NUM_DEV.
  - Per-device base/mask constants (MEM_BASE/MEM_MASK, UART_ADDR/UART_MASK = ~WORD_LEN'b111, ...).
  - State encodings DBUS_IDLE/DBUS_WAIT/DBUS_ERR.
- One sub-module: dbus_addr_match. It is combinational and turns addr, BASE_ADDRS and ADDR_MASKS into a one-hot hit, an index, and a miss flag, with lowest-index priority.
- The top level instantiates dbus_router in place of the hand-written is_uart/delay logic.

Test Plan:
- NUM_DEV=2, mem base 0 mask FFFF0000, uart base 0x10000000 mask FFFFFFF8. Read 0x00000010, mem ready in cycle 1 with rdata 0xDEADBEEF -> d_sel=01 in cycle 0; c_ack=1, c_rdata=0xDEADBEEF, c_err=0 in cycle 1.
- Write 0x10000004 wdata 0x41, uart ready after 3 wait cycles -> d_sel=10 with d_wen=1 for exactly one cycle; c_ack in cycle 4; mem never selected.
- Read 0x20000000 (unmapped) -> d_sel stays 0; c_ack=1, c_err=1, c_rdata=0 in cycle 1; err_valid=1, err_addr=0x20000000.
- TIMEOUT=8, uart never ready -> c_ack with c_err in cycle 8. Then a second error at 0x20000004 -> err_addr still holds the uart address. err_clr with no concurrent error -> err_valid=0.
- Overlapping slots (both base 0, mask 0) -> slot 0 selected. Ready and timeout in the same cycle -> c_err=0.
- rst_n low in WAIT cycle 2 -> all outputs 0 asynchronously. After release, a new read completes normally; no stale ack.
